// File: rtl/tlm_mem_pkg.sv
// -----------------------------------------------------------------------------
// tlm_mem_pkg
// Shared types for the TLM memory-access engine.
//   tlm_cmd_e    : TLM generic-payload command (2 bits)
//   tlm_status_e : response status returned to the front-end (2 bits)
//   ctrl_state_e : controller FSM state
//   check_req()  : legality check of an incoming request
// -----------------------------------------------------------------------------
package tlm_mem_pkg;

    localparam int TLM_DATA_W = 32;
    localparam int TLM_BE_W   = TLM_DATA_W / 8;
    localparam int TLM_CNT_W  = 16;

    typedef enum logic [1:0] {
        TLM_READ     = 2'd0,
        TLM_WRITE    = 2'd1,
        TLM_IGNORE   = 2'd2,
        TLM_RESERVED = 2'd3
    } tlm_cmd_e;

    typedef enum logic [1:0] {
        TLM_OK       = 2'd0,
        TLM_ADDR_ERR = 2'd1,
        TLM_CMD_ERR  = 2'd2,
        TLM_BE_ERR   = 2'd3
    } tlm_status_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } ctrl_state_e;

    // Priority: bad command first, then (for READ/WRITE only) address range,
    // then empty byte-enable mask. IGNORE never touches memory, so its
    // address and byte enables are not checked.
    function automatic tlm_status_e check_req(
        input tlm_cmd_e          cmd,
        input logic [31:0]       addr,
        input logic [TLM_BE_W-1:0] be,
        input int                addr_w
    );
        logic addr_hi;
        tlm_status_e sts;
        addr_hi = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i >= addr_w && addr[i]) begin
                addr_hi = 1'b1;
            end
        end
        if (cmd == TLM_RESERVED) begin
            sts = TLM_CMD_ERR;
        end else if (cmd == TLM_IGNORE) begin
            sts = TLM_OK;
        end else if (addr_hi) begin
            sts = TLM_ADDR_ERR;
        end else if (be == '0) begin
            sts = TLM_BE_ERR;
        end else begin
            sts = TLM_OK;
        end
        return sts;
    endfunction

endpackage

// File: rtl/tlm_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tlm_mem_ctrl
// Executes decoded TLM transactions against a single-port synchronous SRAM,
// one transaction in flight at a time.
//
// Ports
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake
//   req_cmd_i, req_addr_i,
//   req_wdata_i, req_be_i      request payload (word address, byte enables)
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_status_o, rsp_rdata_o  response payload (rdata 0 unless an OK read)
//   mem_addr_o, mem_wdata_o,
//   mem_be_o, mem_we_o,
//   mem_re_o, mem_rdata_i      SRAM port, read data one cycle after mem_re_o
//   txn_cnt_o, err_cnt_o       completed / failed response counters (wrap)
// -----------------------------------------------------------------------------
module tlm_mem_ctrl
    import tlm_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32   // fixed at 32: four byte lanes
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_cmd_i,
    input  logic [31:0]          req_addr_i,
    input  logic [DATA_W-1:0]    req_wdata_i,
    input  logic [DATA_W/8-1:0]  req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [1:0]           rsp_status_o,
    output logic [DATA_W-1:0]    rsp_rdata_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    output logic [DATA_W/8-1:0]  mem_be_o,
    output logic                 mem_we_o,
    output logic                 mem_re_o,
    input  logic [DATA_W-1:0]    mem_rdata_i,
    output logic [TLM_CNT_W-1:0] txn_cnt_o,
    output logic [TLM_CNT_W-1:0] err_cnt_o
);

    ctrl_state_e            state_q,     state_d;
    tlm_cmd_e               cmd_q,       cmd_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    tlm_status_e            status_q,    status_d;
    logic [DATA_W-1:0]      rdata_q,     rdata_d;
    logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0]    mem_be_q,    mem_be_d;
    logic                   mem_we_q,    mem_we_d;
    logic                   mem_re_q,    mem_re_d;
    logic [TLM_CNT_W-1:0]   txn_cnt_q,   txn_cnt_d;
    logic [TLM_CNT_W-1:0]   err_cnt_q,   err_cnt_d;

    tlm_cmd_e               req_cmd;
    tlm_status_e            req_status;
    logic                   req_hs;
    logic                   rsp_hs;

    assign req_cmd    = tlm_cmd_e'(req_cmd_i);
    assign req_status = check_req(req_cmd, req_addr_i, req_be_i, ADDR_W);
    assign req_hs     = req_valid_i && req_ready_q;
    assign rsp_hs     = rsp_valid_q && rsp_ready_i;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        // Strobes are single-cycle pulses covering only the ACCESS state.
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        txn_cnt_d   = txn_cnt_q;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // req_ready is registered, so it first rises one edge after
                // reset release even though the FSM already sits in IDLE.
                req_ready_d = 1'b1;
                if (req_hs) begin
                    req_ready_d = 1'b0;
                    cmd_d       = req_cmd;
                    status_d    = req_status;
                    rdata_d     = '0;
                    if (req_status == TLM_OK &&
                        (req_cmd == TLM_READ || req_cmd == TLM_WRITE)) begin
                        // Memory port registers load here so that address,
                        // data and strobe are all valid throughout ACCESS.
                        state_d    = ST_ACCESS;
                        mem_addr_d = req_addr_i[ADDR_W-1:0];
                        if (req_cmd == TLM_WRITE) begin
                            mem_wdata_d = req_wdata_i;
                            mem_be_d    = req_be_i;
                            mem_we_d    = 1'b1;
                        end else begin
                            mem_re_d    = 1'b1;
                        end
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_ACCESS: begin
                state_d = (cmd_q == TLM_READ) ? ST_RDWAIT : ST_RESP;
            end

            ST_RDWAIT: begin
                // Byte enables only gate writes; reads return the full word.
                rdata_d = mem_rdata_i;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                // rsp_valid is raised one cycle after entering RESP; once up,
                // status and rdata are frozen until the response handshake.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                    txn_cnt_d   = txn_cnt_q + 1'b1;
                    if (status_q != TLM_OK) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            cmd_q       <= TLM_READ;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            status_q    <= TLM_OK;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            txn_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            status_q    <= status_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            txn_cnt_q   <= txn_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_status_o = status_q;
    assign rsp_rdata_o  = rdata_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_be_o     = mem_be_q;
    assign mem_we_o     = mem_we_q;
    assign mem_re_o     = mem_re_q;
    assign txn_cnt_o    = txn_cnt_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
